uart_rx_cfg: RTL

- Configurable UART receiver, successor to the fixed 8N1 receiver on the FPGA <-> Raspberry Pi Pico serial link.
- Adds the following over that receiver:
  - runtime baud divisor
  - 16x oversampling with 3-sample majority vote
  - false-start rejection
  - parity (none/even/odd), 1 or 2 stop bits
  - framing/parity/overrun/break reporting
  - a FIFO with valid/ready output handshake
- Feeds the command decoder, which can stall via i_rx_ready.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_cfg.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types, oversampling constants and helpers for uart_rx_cfg.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int OS_W       = $clog2(OVERSAMPLE);

    localparam logic [OS_W-1:0] SAMPLE_LO  = OS_W'(7);
    localparam logic [OS_W-1:0] SAMPLE_MID = OS_W'(8);
    localparam logic [OS_W-1:0] SAMPLE_HI  = OS_W'(9);
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Synchronous first-word-fall-through FIFO; push/pop together is
//           honoured even when full.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cfg
// Brief   : Configurable 16x-oversampled UART receiver with parity, 1/2 stop
//           bits, error/break reporting and a valid/ready receive FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    input  logic [DIV_W-1:0]     i_baud_div,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_stop2,
    input  logic                 i_clr_err,
    input  logic                 i_rx_ready,
    output logic                 o_rx_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int FW = DATA_BITS + 2;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);

    logic                 r_sync1, r_sync2;
    rx_state_t            r_state;
    parity_t              r_par;
    logic                 r_stop2;
    logic [DIV_W-1:0]     r_div;
    logic [DIV_W-1:0]     r_tick_cnt;
    logic [OS_W-1:0]      r_os_cnt;
    logic                 r_s_lo, r_s_mid;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_perr, r_ferr, r_stop_idx;
    logic                 r_push, r_break, r_overrun;
    logic [FW-1:0]        r_push_data;

    logic             w_active, w_tick, w_sample, w_os_end, w_maj, w_is_break;
    logic [DIV_W-1:0] w_start_reload, w_reload;
    logic [FW-1:0]    w_head;
    logic             w_full, w_empty, w_pop;

    assign w_active       = r_state inside {START, DATA, PARITY, STOP};
    assign w_tick         = w_active && (r_tick_cnt == '0);
    assign w_sample       = w_tick && (r_os_cnt == SAMPLE_HI);
    assign w_os_end       = w_tick && (r_os_cnt == OS_LAST);
    assign w_maj          = maj3(r_s_lo, r_s_mid, r_sync2);
    assign w_start_reload = (i_baud_div == '0) ? '0 : i_baud_div - DIV_W'(1);
    assign w_reload       = (r_div == '0) ? '0 : r_div - DIV_W'(1);
    assign w_is_break     = (r_shift == '0) && !w_maj && ((r_par == PAR_NONE) || !r_par_bit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_par       <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_div       <= '0;
            r_tick_cnt  <= '0;
            r_os_cnt    <= '0;
            r_s_lo      <= 1'b1;
            r_s_mid     <= 1'b1;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_break     <= 1'b0;
        end else begin
            r_push  <= 1'b0;
            r_break <= 1'b0;
            if (w_active) begin
                r_tick_cnt <= (r_tick_cnt == '0) ? w_reload : r_tick_cnt - DIV_W'(1);
            end
            if (w_tick) begin
                r_os_cnt <= w_os_end ? '0 : r_os_cnt + OS_W'(1);
                if (r_os_cnt == SAMPLE_LO)  r_s_lo  <= r_sync2;
                if (r_os_cnt == SAMPLE_MID) r_s_mid <= r_sync2;
            end
            case (r_state)
                IDLE: begin
                    // Config is frozen here so mid-frame changes cannot corrupt the frame.
                    if (!r_sync2) begin
                        r_state    <= START;
                        r_div      <= i_baud_div;
                        r_par      <= decode_parity(i_parity_mode);
                        r_stop2    <= i_stop2;
                        r_tick_cnt <= w_start_reload;
                        r_os_cnt   <= '0;
                        r_bit_idx  <= '0;
                        r_par_bit  <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_stop_idx <= 1'b0;
                    end
                end
                START: begin
                    if (w_sample && w_maj) begin
                        r_state <= IDLE;
                    end else if (w_os_end) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_os_end) begin
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= (r_par == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_par_bit <= w_maj;
                        r_perr    <= w_maj != ((^r_shift) ^ (r_par == PAR_ODD));
                    end
                    if (w_os_end) r_state <= STOP;
                end
                STOP: begin
                    // Push on the final stop sample so the next start edge is never missed.
                    if (w_sample) begin
                        if (!r_stop_idx && w_is_break) begin
                            r_break <= 1'b1;
                            r_state <= BREAK_WAIT;
                        end else if (r_stop_idx || !r_stop2) begin
                            r_push      <= 1'b1;
                            r_push_data <= {r_ferr | ~w_maj, r_perr, r_shift};
                            r_state     <= IDLE;
                        end else begin
                            r_ferr <= ~w_maj;
                        end
                    end else if (w_os_end) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    if (r_sync2) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_pop = !w_empty && i_rx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (r_push && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_rx_valid   = !w_empty;
    assign o_rx_data    = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign o_parity_err = !w_empty && w_head[DATA_BITS];
    assign o_frame_err  = !w_empty && w_head[DATA_BITS+1];
    assign o_overrun    = r_overrun;
    assign o_break      = r_break;
    assign o_busy       = (r_state != IDLE);

endmodule
`default_nettype wire
